// File: rtl/cache_arbiter.sv
// Two-port arbiter that shares one physical-memory port between the I-cache and D-cache.
// Tie-break: fixed D priority by default; round-robin when CACHE_ARB_RR_EN is defined.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
    typedef enum logic {GRANT_I, GRANT_D} grant_t;

    state_t r_state, w_next;
    grant_t r_last_grant;
    logic   w_i_req, w_d_req, w_tie_d;

    assign w_i_req = i_pmem_read;
    assign w_d_req = d_pmem_read | d_pmem_write;

`ifdef CACHE_ARB_RR_EN
    assign w_tie_d = (r_last_grant == GRANT_I);
`else
    // last_grant is tracked in this build too, it just never steers a tie.
    logic w_unused_last;
    assign w_tie_d       = 1'b1;
    assign w_unused_last = r_last_grant;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_last_grant <= GRANT_I;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next != IDLE)
                r_last_grant <= (w_next == SERVE_D) ? GRANT_D : GRANT_I;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_i_req && w_d_req) w_next = w_tie_d ? SERVE_D : SERVE_I;
                else if (w_d_req)       w_next = SERVE_D;
                else if (w_i_req)       w_next = SERVE_I;
            end
            SERVE_I, SERVE_D: if (pmem_resp) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Requesters hold their command stable until resp, so it is forwarded, not latched.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (r_state)
            SERVE_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp & ~reset;
            end
            SERVE_D: begin
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp & ~reset;
            end
            default: ;
        endcase
    end

    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed literal scenarios plus random traffic against a
// transaction-level ownership model. Build with CACHE_ARB_RR_EN to cover round-robin.
module tb_cache_arbiter;
    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_pmem_read = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read = 1'b0, d_pmem_write = 1'b0;
    logic [AW-1:0] d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp = 1'b0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .reset(reset),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Ownership model: who holds the memory port (0 none, 1 I, 2 D) and who held it last.
    int m_own  = 0;
    int m_last = 1;

    always @(posedge clk) begin
        if (reset) begin
            m_own  <= 0;
            m_last <= 1;
        end else if (m_own != 0) begin
            if (pmem_resp) m_own <= 0;
        end else begin
            bit ir, dr;
            int g;
            ir = i_pmem_read;
            dr = d_pmem_read | d_pmem_write;
            g  = 0;
            if (ir && dr) begin
`ifdef CACHE_ARB_RR_EN
                g = (m_last == 1) ? 2 : 1;
`else
                g = 2;
`endif
            end else if (dr) g = 2;
            else if (ir) g = 1;
            if (g != 0) begin
                m_own  <= g;
                m_last <= g;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic          e_rd, e_wr, e_ir, e_dr;
            logic [AW-1:0] e_addr;
            e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_addr = '0;
            if (m_own == 1) begin
                e_rd = i_pmem_read; e_addr = i_pmem_address; e_ir = pmem_resp & ~reset;
            end else if (m_own == 2) begin
                e_rd = d_pmem_read; e_wr = d_pmem_write; e_addr = d_pmem_address;
                e_dr = pmem_resp & ~reset;
            end
            chk("m_read",  LW'(pmem_read),   LW'(e_rd));
            chk("m_write", LW'(pmem_write),  LW'(e_wr));
            chk("m_iresp", LW'(i_pmem_resp), LW'(e_ir));
            chk("m_dresp", LW'(d_pmem_resp), LW'(e_dr));
            chk("m_irdata", i_pmem_rdata, pmem_rdata);
            chk("m_drdata", d_pmem_rdata, pmem_rdata);
            if (m_own != 0) chk("m_addr", LW'(pmem_address), LW'(e_addr));
            if (m_own == 2) chk("m_wdata", pmem_wdata, d_pmem_wdata);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_in();
        i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; pmem_resp = 0;
    endtask

    task automatic do_reset();
        reset = 1; clear_in();
        tick(); tick();
        reset = 0;
    endtask

    initial begin
        logic [3:0] seq;
        int         ng;
        tick();
        chk_en = 1'b1;
        do_reset();

        // reset state outputs
        sample();
        chk("rst_read",  LW'(pmem_read),   '0);
        chk("rst_write", LW'(pmem_write),  '0);
        chk("rst_iresp", LW'(i_pmem_resp), '0);
        chk("rst_dresp", LW'(d_pmem_resp), '0);

        // I read 0x1230, memory responds on the 4th granted cycle
        tick();
        i_pmem_read = 1; i_pmem_address = 16'h1230;
        sample();
        chk("i_req_cycle_idle", LW'(pmem_read), '0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            pmem_resp = (k == 4);
            sample();
            chk("i_read_hi", LW'(pmem_read), LW'(1));
            chk("i_addr", LW'(pmem_address), LW'(16'h1230));
            chk("i_resp", LW'(i_pmem_resp), LW'(k == 4));
            chk("i_dresp0", LW'(d_pmem_resp), '0);
        end
        tick(); clear_in();
        sample();
        chk("i_after_idle", LW'(pmem_read), '0);

        // D write-back 0x4440
        tick();
        d_pmem_write = 1; d_pmem_address = 16'h4440; d_pmem_wdata = {16{8'hA5}};
        tick();
        pmem_resp = 1;
        sample();
        chk("d_write", LW'(pmem_write), LW'(1));
        chk("d_wdata", pmem_wdata, {16{8'hA5}});
        chk("d_addr", LW'(pmem_address), LW'(16'h4440));
        chk("d_resp", LW'(d_pmem_resp), LW'(1));
        tick(); clear_in();
        sample();
        chk("d_after_write", LW'(pmem_write), '0);
        chk("d_after_resp", LW'(d_pmem_resp), '0);

        // Both requesters held, memory answers instantly: record the grant order
        do_reset();
        i_pmem_read = 1; i_pmem_address = 16'h0100;
        d_pmem_read = 1; d_pmem_address = 16'h0200;
        pmem_resp = 1;
        seq = '0; ng = 0;
        for (int c = 0; c < 20 && ng < 4; c++) begin
            sample();
            if (i_pmem_resp || d_pmem_resp) begin
                seq = {seq[2:0], d_pmem_resp};
                ng++;
            end
            tick();
        end
        chk("tie_count", LW'(ng), LW'(4));
`ifdef CACHE_ARB_RR_EN
        chk("tie_order_rr", LW'(seq), LW'(4'b1010));
`else
        chk("tie_order_fixed", LW'(seq), LW'(4'b1111));
`endif
        clear_in();

        // Reset lands while SERVE_D sees its resp
        do_reset();
        d_pmem_read = 1; d_pmem_address = 16'h0AB0;
        tick();
        sample();
        chk("rst_mid_pre", LW'(pmem_read), LW'(1));
        tick();
        reset = 1; pmem_resp = 1;
        tick();
        pmem_resp = 0;
        sample();
        chk("rst_mid_dresp", LW'(d_pmem_resp), '0);
        chk("rst_mid_read",  LW'(pmem_read), '0);
        chk("rst_mid_write", LW'(pmem_write), '0);
        tick(); reset = 0; clear_in();

        // D arrives while I is being served
        tick();
        i_pmem_read = 1; i_pmem_address = 16'h1111;
        tick();
        d_pmem_read = 1; d_pmem_address = 16'h2222;
        for (int k = 0; k < 2; k++) begin
            sample();
            chk("ovl_addr_i", LW'(pmem_address), LW'(16'h1111));
            chk("ovl_dresp0", LW'(d_pmem_resp), '0);
            tick();
        end
        pmem_resp = 1;
        sample();
        chk("ovl_iresp", LW'(i_pmem_resp), LW'(1));
        tick();
        pmem_resp = 0; i_pmem_read = 0;
        sample();
        chk("ovl_gap", LW'(pmem_read), '0);
        tick();
        sample();
        chk("ovl_addr_d", LW'(pmem_address), LW'(16'h2222));
        chk("ovl_read_d", LW'(pmem_read), LW'(1));
        tick(); pmem_resp = 1;
        tick(); clear_in();

        // Random traffic against the ownership model
        for (int c = 0; c < 3000; c++) begin
            tick();
            reset = ($urandom_range(0, 99) < 2);
            if (!i_pmem_read) begin
                if ($urandom_range(0, 3) == 0) begin
                    i_pmem_read = 1; i_pmem_address = AW'($urandom);
                end
            end else if ($urandom_range(0, 19) == 0) i_pmem_read = 0;
            if (!(d_pmem_read || d_pmem_write)) begin
                if ($urandom_range(0, 3) == 0) begin
                    d_pmem_read  = 1'($urandom);
                    d_pmem_write = ~d_pmem_read | 1'($urandom);
                    d_pmem_address = AW'($urandom);
                    d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
                end
            end else if ($urandom_range(0, 19) == 0) begin
                d_pmem_read = 0; d_pmem_write = 0;
            end
            pmem_resp  = ($urandom_range(0, 3) == 0);
            pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
        end
        tick();
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
